phase_sequencer: RTL and testbench

- Parametrised multi-phase timing sequencer for multicycle control in the MIPS processor datapath.
- Steps through NUM_PHASES phases in order. Each phase dwells for a runtime-programmable cycle count.
- Supports stall, abort, one-shot or looping mode, and per-phase/sequence completion pulses.
- Used by multicycle units to sequence fetch/decode/execute/writeback-style control phases.

---
 rtl/phase_sequencer.sv | 157 +++++++++++++++
 tb/tb_phase_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// ---------------------------------------------------------------------------
// phase_sequencer
//
// Multi-phase timing sequencer for multicycle datapath control. It steps
// through NUM_PHASES phases in order, and each phase dwells for a count taken
// live from dwell_cfg. The sequencer supports stall, abort, and one-shot or
// looping operation.
//
// Optional feature: define PHASE_SEQ_SKIP_EN to add skip_mask. Phases whose
// bit is set in skip_mask are skipped and take zero cycles.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   begin a sequence (honoured in IDLE only)
//   stall      in   freeze phase and counter while high (RUN only)
//   abort      in   synchronous cancel, highest priority
//   dwell_cfg  in   NUM_PHASES fields of CNT_W bits, field i = dwell of phase i
//   skip_mask  in   (PHASE_SEQ_SKIP_EN only) per-phase skip bits
//   busy       out  high while running
//   phase      out  current phase index
//   phase_oh   out  one-hot phase while busy, zero when idle
//   count      out  cycles elapsed in the current phase
//   phase_done out  final cycle of a phase (combinational)
//   seq_done   out  final cycle of the last phase (combinational)
// ---------------------------------------------------------------------------
module phase_sequencer #(
  parameter int NUM_PHASES = 4,
  parameter int CNT_W      = 5,
  parameter int LOOP       = 0,
  localparam int PH_W      = ($clog2(NUM_PHASES) > 1) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        stall,
  input  logic                        abort,
  input  logic [NUM_PHASES*CNT_W-1:0] dwell_cfg,
`ifdef PHASE_SEQ_SKIP_EN
  input  logic [NUM_PHASES-1:0]       skip_mask,
`endif
  output logic                        busy,
  output logic [PH_W-1:0]             phase,
  output logic [NUM_PHASES-1:0]       phase_oh,
  output logic [CNT_W-1:0]            count,
  output logic                        phase_done,
  output logic                        seq_done
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] dwell_arr [NUM_PHASES];
  logic [CNT_W-1:0] cur_dwell;
  logic             end_ph;
  logic             adv;
  logic             is_last;
  logic             has_first;
  logic             empty_start;
  logic [PH_W-1:0]  first_phase;
  logic [PH_W-1:0]  nxt_phase;

  always_comb begin
    for (int i = 0; i < NUM_PHASES; i++) begin
      dwell_arr[i] = dwell_cfg[i*CNT_W +: CNT_W];
    end
  end

  assign cur_dwell = dwell_arr[phase];
  // The >= compare makes a dwell lowered mid-phase end the phase at once.
  assign end_ph    = (count >= cur_dwell);
  assign adv       = (state == RUN) && !abort && !stall && end_ph;

`ifdef PHASE_SEQ_SKIP_EN
  logic has_next;

  // Descending scans leave the lowest qualifying index as the result.
  always_comb begin
    has_first   = 1'b0;
    first_phase = '0;
    has_next    = 1'b0;
    nxt_phase   = '0;
    for (int i = NUM_PHASES - 1; i >= 0; i--) begin
      if (!skip_mask[i]) begin
        has_first   = 1'b1;
        first_phase = PH_W'(i);
        if (PH_W'(i) > phase) begin
          has_next  = 1'b1;
          nxt_phase = PH_W'(i);
        end
      end
    end
  end

  assign is_last     = !has_next;
  // A fully masked start completes instantly without leaving IDLE.
  assign empty_start = (state == IDLE) && start && !abort && !has_first;
`else
  assign has_first   = 1'b1;
  assign first_phase = '0;
  assign nxt_phase   = phase + PH_W'(1);
  assign is_last     = (phase == PH_W'(NUM_PHASES - 1));
  assign empty_start = 1'b0;
`endif

  assign phase_done = adv;
  assign seq_done   = (adv && is_last) || empty_start;
  assign busy       = (state == RUN);

  always_comb begin
    phase_oh = '0;
    if (busy) begin
      phase_oh[phase] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      phase <= '0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort && has_first) begin
            state <= RUN;
            phase <= first_phase;
            count <= '0;
          end
        end
        default: begin
          if (abort) begin
            state <= IDLE;
            phase <= '0;
            count <= '0;
          end else if (!stall) begin
            if (!end_ph) begin
              count <= count + CNT_W'(1);
            end else begin
              count <= '0;
              if (!is_last) begin
                phase <= nxt_phase;
              end else if ((LOOP != 0) && has_first) begin
                phase <= first_phase;
              end else begin
                state <= IDLE;
                phase <= '0;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
module tb_phase_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stall, abort;
  logic [19:0] dwell_cfg;
  logic [3:0]  skip_mask;

  logic        busy0, pd0, sd0, busy1, pd1, sd1;
  logic [1:0]  phase0, phase1;
  logic [3:0]  oh0, oh1;
  logic [4:0]  count0, count1;

  localparam logic [19:0] DW = {5'd2, 5'd0, 5'd7, 5'd3};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  phase_sequencer #(.NUM_PHASES(4), .CNT_W(5), .LOOP(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .abort(abort),
    .dwell_cfg(dwell_cfg),
`ifdef PHASE_SEQ_SKIP_EN
    .skip_mask(skip_mask),
`endif
    .busy(busy0), .phase(phase0), .phase_oh(oh0), .count(count0),
    .phase_done(pd0), .seq_done(sd0)
  );

  phase_sequencer #(.NUM_PHASES(4), .CNT_W(5), .LOOP(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .abort(abort),
    .dwell_cfg(dwell_cfg),
`ifdef PHASE_SEQ_SKIP_EN
    .skip_mask(skip_mask),
`endif
    .busy(busy1), .phase(phase1), .phase_oh(oh1), .count(count1),
    .phase_done(pd1), .seq_done(sd1)
  );

  typedef struct {
    logic       start, stall, abort;
    logic       busy;
    logic [1:0] phase;
    logic [4:0] count;
    logic       pd, sd;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t mk(logic st, logic sl, logic ab, logic b,
                              logic [1:0] p, logic [4:0] c, logic pd, logic sd);
    vec_t v;
    v.start = st; v.stall = sl; v.abort = ab;
    v.busy = b; v.phase = p; v.count = c; v.pd = pd; v.sd = sd;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clean();
    abort = 1'b1;
    next_cycle();
    abort = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    next_cycle();
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_oh;
    int sd_rc, sd_n, bad, nb;
    logic sd_seen;

    // One-shot run, then IDLE-only checks (stall ignored, start+abort).
    tbl[0]  = mk(1,0,0, 0,0,0,0,0);
    tbl[1]  = mk(0,0,0, 1,0,0,0,0);
    tbl[2]  = mk(0,0,0, 1,0,1,0,0);
    tbl[3]  = mk(0,0,0, 1,0,2,0,0);
    tbl[4]  = mk(0,0,0, 1,0,3,1,0);
    tbl[5]  = mk(0,0,0, 1,1,0,0,0);
    tbl[6]  = mk(0,0,0, 1,1,1,0,0);
    tbl[7]  = mk(0,0,0, 1,1,2,0,0);
    tbl[8]  = mk(0,0,0, 1,1,3,0,0);
    tbl[9]  = mk(0,0,0, 1,1,4,0,0);
    tbl[10] = mk(0,0,0, 1,1,5,0,0);
    tbl[11] = mk(0,0,0, 1,1,6,0,0);
    tbl[12] = mk(0,0,0, 1,1,7,1,0);
    tbl[13] = mk(0,0,0, 1,2,0,1,0);
    tbl[14] = mk(0,0,0, 1,3,0,0,0);
    tbl[15] = mk(0,0,0, 1,3,1,0,0);
    tbl[16] = mk(0,0,0, 1,3,2,1,1);
    tbl[17] = mk(0,0,0, 0,0,0,0,0);
    tbl[18] = mk(0,1,0, 0,0,0,0,0);
    tbl[19] = mk(1,0,1, 0,0,0,0,0);
    tbl[20] = mk(0,0,0, 0,0,0,0,0);

    rst = 1'b1; start = 1'b0; stall = 1'b0; abort = 1'b0;
    dwell_cfg = DW; skip_mask = 4'b0000;

    @(negedge clk);
    chk("reset_dut0", {busy0, phase0, count0, pd0, sd0, oh0}, 32'h0);
    chk("reset_dut1", {busy1, phase1, count1, pd1, sd1, oh1}, 32'h0);
    next_cycle();
    rst = 1'b0;

    for (int k = 0; k < 21; k++) begin
      start = tbl[k].start; stall = tbl[k].stall; abort = tbl[k].abort;
      @(negedge clk);
      exp_oh = tbl[k].busy ? (4'b0001 << tbl[k].phase) : 4'b0000;
      chk($sformatf("vec%0d", k), {busy0, phase0, count0, pd0, sd0, oh0},
          {tbl[k].busy, tbl[k].phase, tbl[k].count, tbl[k].pd, tbl[k].sd, exp_oh});
      next_cycle();
    end
    start = 1'b0; stall = 1'b0; abort = 1'b0;

    // Asynchronous reset mid-sequence.
    pulse_start();
    for (int rc = 1; rc < 6; rc++) next_cycle();
    #2 rst = 1'b1;
    #1 chk("async_rst", {busy0, phase0, count0, oh0}, 32'h0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("after_rst_idle", {busy0, busy1}, 32'h0);
    next_cycle();

    // Stall for 5 cycles at phase 1, count 4.
    pulse_start();
    sd_rc = 0;
    for (int rc = 1; rc <= 25; rc++) begin
      stall = (rc >= 9 && rc <= 13);
      @(negedge clk);
      if (stall) begin
        chk($sformatf("stall_hold%0d", rc), {phase0, count0, pd0, sd0}, {2'd1, 5'd4, 1'b0, 1'b0});
      end
      if (sd0 && sd_rc == 0) sd_rc = rc;
      next_cycle();
    end
    stall = 1'b0;
    chk("stall_seq_done_cycle", sd_rc, 21);
    chk("stall_end_idle", busy0, 0);
    clean();

    // Abort in phase 2.
    pulse_start();
    sd_seen = 1'b0;
    for (int rc = 1; rc <= 13; rc++) begin
      abort = (rc == 13);
      @(negedge clk);
      if (sd0) sd_seen = 1'b1;
      if (rc == 13) chk("abort_cycle", {phase0, pd0, sd0}, {2'd2, 1'b0, 1'b0});
      next_cycle();
    end
    abort = 1'b0;
    @(negedge clk);
    chk("abort_idle", {busy0, phase0, count0, oh0}, 32'h0);
    for (int rc = 0; rc < 20; rc++) begin
      @(negedge clk);
      if (sd0 || busy0) sd_seen = 1'b1;
      next_cycle();
    end
    chk("abort_no_seq_done", sd_seen, 0);
    start = 1'b1; abort = 1'b1;
    next_cycle();
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("start_abort_idle", {busy0, busy1}, 32'h0);
    next_cycle();

    // LOOP=1 instance wraps 3->0 with busy held.
    pulse_start();
    sd_n = 0; bad = 0; nb = 0;
    for (int rc = 1; rc <= 50; rc++) begin
      abort = (rc == 50);
      @(negedge clk);
      if (!busy1) nb++;
      if (sd1) begin
        sd_n++;
        if (rc != 16 && rc != 32 && rc != 48) bad++;
      end
      if (rc == 16) chk("loop_last_phase", {phase1, pd1, sd1}, {2'd3, 1'b1, 1'b1});
      if (rc == 17) chk("loop_wrap", {busy1, phase1, count1}, {1'b1, 2'd0, 5'd0});
      next_cycle();
    end
    abort = 1'b0;
    chk("loop_seq_done_count", sd_n, 3);
    chk("loop_seq_done_pos", bad, 0);
    chk("loop_busy_held", nb, 0);
    @(negedge clk);
    chk("loop_abort_idle", busy1, 0);
    next_cycle();

    // Lower phase 1 dwell to 2 while count is 6.
    pulse_start();
    for (int rc = 1; rc <= 12; rc++) begin
      if (rc == 11) dwell_cfg[9:5] = 5'd2;
      @(negedge clk);
      if (rc == 11) chk("rewrite_end", {phase0, count0, pd0}, {2'd1, 5'd6, 1'b1});
      if (rc == 12) chk("rewrite_next", {phase0, count0}, {2'd2, 5'd0});
      next_cycle();
      dwell_cfg = DW;
    end
    clean();

`ifdef PHASE_SEQ_SKIP_EN
    skip_mask = 4'b0101;
    pulse_start();
    sd_rc = 0;
    for (int rc = 1; rc <= 15; rc++) begin
      @(negedge clk);
      if (rc == 1) chk("skip_first", {busy0, phase0}, {1'b1, 2'd1});
      if (rc == 9) chk("skip_jump", {phase0, count0}, {2'd3, 5'd0});
      if (sd0 && sd_rc == 0) sd_rc = rc;
      next_cycle();
    end
    chk("skip_seq_done_cycle", sd_rc, 11);
    chk("skip_end_idle", busy0, 0);
    clean();
    skip_mask = 4'hF;
    start = 1'b1;
    @(negedge clk);
    chk("skip_all_pulse", {sd0, busy0}, {1'b1, 1'b0});
    next_cycle();
    start = 1'b0;
    @(negedge clk);
    chk("skip_all_idle", {busy0, busy1}, 32'h0);
    skip_mask = 4'b0000;
    next_cycle();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
